load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Sequential MEM-stage load/store engine; replaces the purely combinational data-memory interface.
//  Takes a byte address plus MEM control and drives a handshaked word-wide data memory port,
//  generating byte-enables, lane-replicated store data and lane-extracted sign/zero-extended loads.
//  Flags misaligned accesses, illegal control and memory timeout; stalls the pipeline while busy.
// PARAMETERS
//  NB_DATA      32  data width; byte lanes = NB_DATA/8 (4)
//  NB_ADDR       9  byte-address width (128 words x 4 bytes)
//  NB_MEM_CTRL   6  control width: [5]=read [4]=write [3:1]=size onehot 001 byte/010 half/100 word; [0]=1 zero-extend
//  TIMEOUT      15  max ACCESS cycles waiting for mem_ready_i
// PORTS
//  clock_i        in   1              clock, rising edge
//  reset_i        in   1              synchronous, active-high
//  start_i        in   1              request present this cycle
//  MEM_control_i  in   NB_MEM_CTRL    access control (encoding above)
//  addr_i         in   NB_ADDR        byte address
//  data_write_i   in   NB_DATA        store data, right-aligned
//  data_read_o    out  NB_DATA        load result, registered, held until next load completes
//  valid_o        out  1              one-cycle pulse: access completed
//  stall_o        out  1              hold pipeline
//  err_o          out  1              one-cycle pulse: access aborted
//  err_code_o     out  2              01 misaligned, 10 illegal ctrl, 11 timeout; held until next err
//  mem_en_o       out  1              memory request
//  mem_we_o       out  1              1=write
//  mem_addr_o     out  NB_ADDR-2      word address = addr_i[NB_ADDR-1:2]
//  mem_be_o       out  NB_DATA/8      byte enables (writes; 1111 on reads)
//  mem_wdata_o    out  NB_DATA        lane-replicated store data
//  mem_rdata_i    in   NB_DATA        memory read word
//  mem_ready_i    in   1              memory completes request this cycle
// BEHAVIOUR
//  Reset: state IDLE; data_read_o, err_code_o, all mem_* outputs = 0; valid_o/err_o/stall_o = 0; counter = 0.
//  FSM IDLE -> ACCESS -> DONE -> IDLE; IDLE -> ERR -> IDLE; ACCESS -> ERR (timeout).
//  IDLE: start_i with read^write set. Check order: illegal ctrl (read&write, or size not onehot) -> ERR code 10;
//   misaligned (half addr[0]!=0, word addr[1:0]!=0) -> ERR code 01; else latch addr/ctrl/data, -> ACCESS.
//   start_i with neither read nor write: ignored, no stall.
//  stall_o = (IDLE & start_i & (read|write)) | ACCESS. Low in DONE/ERR so pipeline advances on that edge.
//  ACCESS: mem_en_o=1, registered outputs stable for whole state. Counter counts cycles.
//   mem_ready_i=1 -> DONE (loads capture extracted mem_rdata_i into data_read_o at that edge).
//   TIMEOUT cycles without ready -> ERR code 11, mem_en_o drops; ready on the TIMEOUT-th cycle = success.
//  DONE: valid_o=1 one cycle -> IDLE. start_i in DONE/ERR ignored (same instruction).
//  ERR: err_o=1 one cycle; no memory access was/remains issued; data_read_o unchanged -> IDLE.
//  Latency: accept edge +1 ACCESS; ready in first ACCESS cycle -> valid_o 2 cycles after accept.
//  Store lanes, k=addr[1:0]: byte be=1<<k, wdata={4{d[7:0]}}; half be=0011(k=0)/1100(k=2), wdata={2{d[15:0]}};
//   word be=1111, wdata=d.
//  Load extract: lane=mem_rdata_i >> 8*k; byte/half sign-extend if ctrl[0]=0, else zero-extend; word as is.
//  mem_ready_i outside ACCESS ignored. reset_i in any state returns to IDLE next edge, mem_en_o=0, no valid/err pulse.
// TESTING
//  LB ctrl 6'b100010 addr 0x003, rdata 0x80FF1234, ready immediate -> mem_addr 0, data_read_o 0xFFFFFF80, valid 2 cyc after accept.
//  LBU ctrl 6'b100011 same stimulus -> data_read_o 0x00000080; LHU addr 0x002 -> 0x000080FF.
//  SH ctrl 6'b010100 addr 0x006 data 0x0000ABCD -> mem_we 1, mem_addr 1, be 1100, wdata 0xABCDABCD.
//  LW ctrl 6'b101000 addr 0x005 -> err_o pulse, code 01, mem_en_o never high; ctrl 6'b111000 -> code 10.
//  LW aligned, mem_ready_i low 15 cycles -> err code 11, mem_en drops; ready on 15th cycle -> valid instead.
//  reset_i asserted in 3rd ACCESS cycle -> next cycle IDLE, all outputs 0, no valid_o/err_o pulse.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store engine. Turns a byte address plus MEM
// control into a handshaked word-wide memory request. It generates byte enables
// and lane-replicated store data, and it extracts and extends load data from the
// returned word. Misaligned and illegal requests are rejected without touching
// memory. A request that never sees mem_ready_i is aborted after TIMEOUT cycles.
module load_store_unit #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDR     = 9,
  parameter int NB_MEM_CTRL = 6,
  parameter int TIMEOUT     = 15
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NB_MEM_CTRL-1:0] MEM_control_i,
  input  logic [NB_ADDR-1:0]     addr_i,
  input  logic [NB_DATA-1:0]     data_write_i,
  output logic [NB_DATA-1:0]     data_read_o,
  output logic                   valid_o,
  output logic                   stall_o,
  output logic                   err_o,
  output logic [1:0]             err_code_o,
  output logic                   mem_en_o,
  output logic                   mem_we_o,
  output logic [NB_ADDR-3:0]     mem_addr_o,
  output logic [NB_DATA/8-1:0]   mem_be_o,
  output logic [NB_DATA-1:0]     mem_wdata_o,
  input  logic [NB_DATA-1:0]     mem_rdata_i,
  input  logic                   mem_ready_i
);

  localparam int NB_LANES = NB_DATA / 8;
  localparam int LANE_W   = $clog2(NB_LANES);
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t                   state_q, state_d;
  logic [NB_MEM_CTRL-1:0]   ctrl_q, ctrl_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [NB_ADDR-3:0]       memAddr_q, memAddr_d;
  logic [NB_LANES-1:0]      memBe_q, memBe_d;
  logic [NB_DATA-1:0]       memWdata_q, memWdata_d;
  logic [NB_DATA-1:0]       dataRead_q, dataRead_d;
  logic [1:0]               errCode_q, errCode_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     reqRead, reqWrite, reqValid;
  logic [2:0]               reqSize;
  logic                     illegalCtrl, misaligned;
  logic [NB_LANES-1:0]      beIn;
  logic [NB_DATA-1:0]       wdataIn;
  logic [LANE_W+2:0]        rdShamt;
  logic [NB_DATA-1:0]       rdShift;
  logic [NB_DATA-1:0]       loadExt;

  assign reqRead  = MEM_control_i[5];
  assign reqWrite = MEM_control_i[4];
  assign reqSize  = MEM_control_i[3:1];
  assign reqValid = start_i & (reqRead | reqWrite);

  assign illegalCtrl = (reqRead & reqWrite) |
                       ~((reqSize == 3'b001) | (reqSize == 3'b010) | (reqSize == 3'b100));
  assign misaligned  = ((reqSize == 3'b010) & addr_i[0]) |
                       ((reqSize == 3'b100) & (|addr_i[1:0]));

  // Store-side lane placement from the incoming request: byte enables and replicated data.
  always_comb begin
    beIn    = '1;
    wdataIn = data_write_i;
    if (reqRead) begin
      beIn    = '1;
      wdataIn = data_write_i;
    end else if (reqSize == 3'b001) begin
      beIn    = {{(NB_LANES-1){1'b0}}, 1'b1} << addr_i[LANE_W-1:0];
      wdataIn = {NB_LANES{data_write_i[7:0]}};
    end else if (reqSize == 3'b010) begin
      beIn    = {{(NB_LANES-2){1'b0}}, 2'b11} << addr_i[LANE_W-1:0];
      wdataIn = {(NB_LANES/2){data_write_i[15:0]}};
    end
  end

  assign rdShamt = {lane_q, 3'b000};
  assign rdShift = mem_rdata_i >> rdShamt;

  // Load-side lane extraction with sign or zero extension chosen by the latched control.
  always_comb begin
    loadExt = rdShift;
    case (ctrl_q[3:1])
      3'b001:  loadExt = {{(NB_DATA-8){~ctrl_q[0] & rdShift[7]}}, rdShift[7:0]};
      3'b010:  loadExt = {{(NB_DATA-16){~ctrl_q[0] & rdShift[15]}}, rdShift[15:0]};
      default: loadExt = rdShift;
    endcase
  end

  // Next-state logic: accept or reject requests in IDLE, wait for memory or timeout in ACCESS.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    lane_d     = lane_q;
    memAddr_d  = memAddr_q;
    memBe_d    = memBe_q;
    memWdata_d = memWdata_q;
    dataRead_d = dataRead_q;
    errCode_d  = errCode_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          if (illegalCtrl) begin
            state_d   = ERR;
            errCode_d = 2'b10;
          end else if (misaligned) begin
            state_d   = ERR;
            errCode_d = 2'b01;
          end else begin
            state_d    = ACCESS;
            ctrl_d     = MEM_control_i;
            lane_d     = addr_i[LANE_W-1:0];
            memAddr_d  = addr_i[NB_ADDR-1:2];
            memBe_d    = beIn;
            memWdata_d = wdataIn;
            cnt_d      = '0;
          end
        end
      end
      ACCESS: begin
        if (mem_ready_i) begin
          state_d = DONE;
          if (ctrl_q[5]) begin
            dataRead_d = loadExt;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d   = ERR;
          errCode_d = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      lane_q     <= '0;
      memAddr_q  <= '0;
      memBe_q    <= '0;
      memWdata_q <= '0;
      dataRead_q <= '0;
      errCode_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      lane_q     <= lane_d;
      memAddr_q  <= memAddr_d;
      memBe_q    <= memBe_d;
      memWdata_q <= memWdata_d;
      dataRead_q <= dataRead_d;
      errCode_q  <= errCode_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_en_o    = (state_q == ACCESS);
  assign mem_we_o    = ctrl_q[4];
  assign mem_addr_o  = memAddr_q;
  assign mem_be_o    = memBe_q;
  assign mem_wdata_o = memWdata_q;
  assign data_read_o = dataRead_q;
  assign err_code_o  = errCode_q;
  assign valid_o     = (state_q == DONE);
  assign err_o       = (state_q == ERR);
  assign stall_o     = ((state_q == IDLE) & reqValid) | (state_q == ACCESS);

endmodule
